rob_alloc_ctrl: RTL and testbench

Allocation controller for ROB tags requested by the rename stage. It owns the ROB tail/head pointers and the occupancy count, and grants up to PIPE_WIDTH in-order tags per cycle. It retires entries on commit and collapses the allocation window on flush. It sits between rename (req/gnt/tags, rename_rdy as the accept) and the ROB storage/commit logic.

---
 rtl/rob_alloc_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rob_alloc_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc_ctrl.sv
// ============================================================================
// rob_alloc_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Hands out in-order ROB tags to the rename stage (up to PIPE_WIDTH per
//   cycle), owns the ROB head/tail pointers and the live-entry count, retires
//   entries on commit and collapses the allocation window on flush.
//
// Optional feature (compile-time macro):
//   ROB_ALLOC_PERF_EN - when defined, stall_cycles counts cycles in which rename
//                       requested slots but at least one requested slot was
//                       denied (saturating, cleared by rst). When undefined the
//                       counter does not exist and stall_cycles reads 0.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset (beats flush/commit/alloc)
//   flush          discard every outstanding entry
//   alloc_req      per-slot request from rename
//   alloc_ack      rename accepted the granted group this cycle
//   alloc_gnt      per-slot grant (combinational, same cycle as the request)
//   alloc_tags     per-slot tag (tail + number of requesting lower slots)
//   commit_valid   in-order retire strobes from the ROB head
//   head_ptr       oldest live entry
//   tail_ptr       next tag to allocate
//   occupancy      number of live entries
//   rob_full       occupancy == ROB_ENTRIES
//   rob_empty      occupancy == 0
//   underflow_err  sticky: a commit asked for more entries than were live
//   stall_cycles   allocation stall counter (see ROB_ALLOC_PERF_EN)
// ============================================================================
module rob_alloc_ctrl #(
    parameter int PIPE_WIDTH  = 2,
    parameter int ROB_ENTRIES = 32,
    parameter int TAG_WIDTH   = $clog2(ROB_ENTRIES)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [PIPE_WIDTH-1:0]                 alloc_req,
    input  logic                                  alloc_ack,
    output logic [PIPE_WIDTH-1:0]                 alloc_gnt,
    output logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]  alloc_tags,
    input  logic [PIPE_WIDTH-1:0]                 commit_valid,
    output logic [TAG_WIDTH-1:0]                  head_ptr,
    output logic [TAG_WIDTH-1:0]                  tail_ptr,
    output logic [TAG_WIDTH:0]                    occupancy,
    output logic                                  rob_full,
    output logic                                  rob_empty,
    output logic                                  underflow_err,
    output logic [31:0]                           stall_cycles
);

    // Counts and occupancy share one extra bit over the pointers so that a
    // completely full ROB (occupancy == ROB_ENTRIES) is representable.
    localparam int            CW      = TAG_WIDTH + 1;
    localparam logic [CW-1:0] ENTRIES = CW'(ROB_ENTRIES);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [TAG_WIDTH-1:0] head_q, head_d;
    logic [TAG_WIDTH-1:0] tail_q, tail_d;
    logic [CW-1:0]        occ_q,  occ_d;
    logic                 underflow_q, underflow_d;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Pointer advance with an explicit wrap compare, so ROB_ENTRIES need not
    // be a power of two. n never exceeds ROB_ENTRIES, so one subtract suffices.
    function automatic logic [TAG_WIDTH-1:0] ptr_add(
        input logic [TAG_WIDTH-1:0] p,
        input logic [CW-1:0]        n
    );
        logic [CW-1:0] s;
        s = {1'b0, p} + n;
        if (s > ENTRIES - CW'(1)) begin
            s = s - ENTRIES;
        end
        return s[TAG_WIDTH-1:0];
    endfunction

    function automatic logic [CW-1:0] popcnt(input logic [PIPE_WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Free space comes from the registered occupancy only: entries retired
    // this cycle cannot be handed out again in the same cycle.
    logic [CW-1:0] free_cnt;
    assign free_cnt = ENTRIES - occ_q;

    // ------------------------------------------------------------------------
    // Per-slot grant and tag
    // ------------------------------------------------------------------------
    // Slot gi needs room for itself plus every requesting slot below it. The
    // requirement is monotonic in gi, so a denied requesting slot automatically
    // denies every higher slot and grants stay in order.
    generate
        for (genvar gi = 0; gi < PIPE_WIDTH; gi++) begin : g_slot
            logic [CW-1:0] lower_cnt;

            always_comb begin
                lower_cnt = '0;
                for (int j = 0; j < gi; j++) begin
                    lower_cnt = lower_cnt + CW'(alloc_req[j]);
                end
            end

            assign alloc_gnt[gi]  = !rst && !flush && alloc_req[gi] &&
                                    (free_cnt >= lower_cnt + CW'(1));
            assign alloc_tags[gi] = rst ? '0 : ptr_add(tail_q, lower_cnt);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic          req_denied;
    logic          alloc_fire;
    logic [CW-1:0] alloc_n;
    logic [CW-1:0] commit_n;
    logic [CW-1:0] commit_eff;
    logic          underflow_hit;

    always_comb begin
        req_denied    = |(alloc_req & ~alloc_gnt);
        alloc_n       = popcnt(alloc_req & alloc_gnt);
        // Acking a partially granted group is a protocol error: nothing is
        // consumed, which keeps the tags rename saw contiguous next time.
        alloc_fire    = alloc_ack && !flush && !req_denied;

        commit_n      = popcnt(commit_valid);
        underflow_hit = commit_n > occ_q;
        commit_eff    = underflow_hit ? '0 : commit_n;

        head_d        = ptr_add(head_q, commit_eff);
        underflow_d   = underflow_q | underflow_hit;

        if (flush) begin
            // Commits of the flush cycle land first; the window then collapses
            // onto the post-commit head.
            tail_d = head_d;
            occ_d  = '0;
        end else begin
            tail_d = ptr_add(tail_q, alloc_fire ? alloc_n : '0);
            occ_d  = occ_q + (alloc_fire ? alloc_n : '0) - commit_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            underflow_q <= underflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stall counter
    // ------------------------------------------------------------------------
`ifdef ROB_ALLOC_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic        stall_hit;

    always_comb begin
        stall_hit = (|alloc_req) && !flush && req_denied;
        stall_d   = stall_q;
        if (stall_hit && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    // ------------------------------------------------------------------------
    // Outputs (straight from registered state)
    // ------------------------------------------------------------------------
    assign head_ptr      = head_q;
    assign tail_ptr      = tail_q;
    assign occupancy     = occ_q;
    assign rob_full      = (occ_q == ENTRIES);
    assign rob_empty     = (occ_q == '0);
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// ============================================================================
// tb_rob_alloc_ctrl
// ----------------------------------------------------------------------------
// Directed bench for rob_alloc_ctrl with ROB_ENTRIES = 8 and PIPE_WIDTH = 2.
// Inputs change 1 ns after the rising edge; combinational outputs are checked
// 1 ns later and registered state is checked 1 ns after the edge that loads it.
// ============================================================================
module tb_rob_alloc_ctrl;

    localparam int PW = 2;
    localparam int NE = 8;
    localparam int TW = $clog2(NE);

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic [PW-1:0]         alloc_req;
    logic                  alloc_ack;
    logic [PW-1:0]         alloc_gnt;
    logic [PW-1:0][TW-1:0] alloc_tags;
    logic [PW-1:0]         commit_valid;
    logic [TW-1:0]         head_ptr;
    logic [TW-1:0]         tail_ptr;
    logic [TW:0]           occupancy;
    logic                  rob_full;
    logic                  rob_empty;
    logic                  underflow_err;
    logic [31:0]           stall_cycles;

    int checks   = 0;
    int failures = 0;

    rob_alloc_ctrl #(
        .PIPE_WIDTH  (PW),
        .ROB_ENTRIES (NE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alloc_req     (alloc_req),
        .alloc_ack     (alloc_ack),
        .alloc_gnt     (alloc_gnt),
        .alloc_tags    (alloc_tags),
        .commit_valid  (commit_valid),
        .head_ptr      (head_ptr),
        .tail_ptr      (tail_ptr),
        .occupancy     (occupancy),
        .rob_full      (rob_full),
        .rob_empty     (rob_empty),
        .underflow_err (underflow_err),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stall count: two denied non-flush cycles occur in this run.
`ifdef ROB_ALLOC_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd2;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1; flush = 1'b0; alloc_req = 2'b11; alloc_ack = 1'b1; commit_valid = 2'b00;
        #1;
        chk("rst_gnt",  32'(alloc_gnt),     32'd0);
        chk("rst_tag0", 32'(alloc_tags[0]), 32'd0);
        chk("rst_tag1", 32'(alloc_tags[1]), 32'd0);
        tick();
        chk("rst_head",  32'(head_ptr),      32'd0);
        chk("rst_tail",  32'(tail_ptr),      32'd0);
        chk("rst_occ",   32'(occupancy),     32'd0);
        chk("rst_empty", 32'(rob_empty),     32'd1);
        chk("rst_full",  32'(rob_full),      32'd0);
        chk("rst_uf",    32'(underflow_err), 32'd0);
        chk("rst_stall", stall_cycles,       32'd0);

        // ---------------- fill: tags (0,1)(2,3)(4,5)(6,7) ----------------
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fill_gnt",  32'(alloc_gnt),     32'd3);
            chk("fill_tag0", 32'(alloc_tags[0]), 32'(2 * k));
            chk("fill_tag1", 32'(alloc_tags[1]), 32'(2 * k + 1));
            tick();
        end
        chk("full_occ",  32'(occupancy), 32'd8);
        chk("full_flag", 32'(rob_full),  32'd1);
        chk("full_tail", 32'(tail_ptr),  32'd0);
        chk("full_empty",32'(rob_empty), 32'd0);

        // ---------------- full: commit 2 + req 2 same cycle ----------------
        commit_valid = 2'b11;
        #1;
        chk("full_gnt", 32'(alloc_gnt), 32'd0);
        tick();                                   // denied cycle #1
        commit_valid = 2'b00;
        chk("cf_occ",  32'(occupancy), 32'd6);
        chk("cf_head", 32'(head_ptr),  32'd2);
        chk("cf_tail", 32'(tail_ptr),  32'd0);
        #1;
        chk("cf_gnt",  32'(alloc_gnt),     32'd3);
        chk("cf_tag0", 32'(alloc_tags[0]), 32'd0);
        chk("cf_tag1", 32'(alloc_tags[1]), 32'd1);
        tick();
        chk("refill_occ",  32'(occupancy), 32'd8);
        chk("refill_tail", 32'(tail_ptr),  32'd2);

        // ---------------- move to head=5 tail=4 occ=7 ----------------
        alloc_req = 2'b00; alloc_ack = 1'b0; commit_valid = 2'b11;
        tick();                                   // h4 t2 o6
        alloc_req = 2'b11; alloc_ack = 1'b1; commit_valid = 2'b00;
        #1;
        chk("mv_gnt",  32'(alloc_gnt),     32'd3);
        chk("mv_tag0", 32'(alloc_tags[0]), 32'd2);
        chk("mv_tag1", 32'(alloc_tags[1]), 32'd3);
        tick();                                   // h4 t4 o8
        alloc_req = 2'b00; alloc_ack = 1'b0; commit_valid = 2'b01;
        tick();                                   // h5 t4 o7
        chk("mv_head", 32'(head_ptr),  32'd5);
        chk("mv_occ",  32'(occupancy), 32'd7);

        // ---------------- req=10 with commit: slot 1 takes tag=tail ----------------
        alloc_req = 2'b10; alloc_ack = 1'b1; commit_valid = 2'b01;
        #1;
        chk("r10_gnt",  32'(alloc_gnt),     32'd2);
        chk("r10_tag1", 32'(alloc_tags[1]), 32'd4);
        tick();
        chk("r10_head", 32'(head_ptr),  32'd6);
        chk("r10_tail", 32'(tail_ptr),  32'd5);
        chk("r10_occ",  32'(occupancy), 32'd7);

        // ---------------- flush with 2 commits, head wraps 6->0 ----------------
        alloc_req = 2'b11; alloc_ack = 1'b1; commit_valid = 2'b11; flush = 1'b1;
        #1;
        chk("fl1_gnt", 32'(alloc_gnt), 32'd0);
        tick();
        flush = 1'b0; commit_valid = 2'b00;
        chk("fl1_head",  32'(head_ptr),  32'd0);
        chk("fl1_tail",  32'(tail_ptr),  32'd0);
        chk("fl1_occ",   32'(occupancy), 32'd0);
        chk("fl1_empty", 32'(rob_empty), 32'd1);

        // ---------------- allocate up to occ=7 tail=7 ----------------
        tick(); tick(); tick();                   // t6 o6
        alloc_req = 2'b01;
        #1;
        chk("a7_gnt",  32'(alloc_gnt),     32'd1);
        chk("a7_tag0", 32'(alloc_tags[0]), 32'd6);
        tick();
        chk("a7_tail", 32'(tail_ptr),  32'd7);
        chk("a7_occ",  32'(occupancy), 32'd7);

        // ---------------- one free slot, two requested, ack -> no movement ----------------
        alloc_req = 2'b11;
        #1;
        chk("part_gnt",  32'(alloc_gnt),     32'd1);
        chk("part_tag0", 32'(alloc_tags[0]), 32'd7);
        tick();                                   // denied cycle #2
        chk("part_tail", 32'(tail_ptr),  32'd7);
        chk("part_occ",  32'(occupancy), 32'd7);

        // ---------------- flush with 1 commit ----------------
        commit_valid = 2'b01; flush = 1'b1;
        #1;
        chk("fl2_gnt", 32'(alloc_gnt), 32'd0);
        tick();
        flush = 1'b0; commit_valid = 2'b00;
        chk("fl2_head",  32'(head_ptr),  32'd1);
        chk("fl2_tail",  32'(tail_ptr),  32'd1);
        chk("fl2_occ",   32'(occupancy), 32'd0);
        chk("fl2_empty", 32'(rob_empty), 32'd1);

        // ---------------- underflow: occ=1, commit 2 ----------------
        alloc_req = 2'b01;
        tick();
        chk("uf_pre_occ", 32'(occupancy),     32'd1);
        chk("uf_pre_flag",32'(underflow_err), 32'd0);
        alloc_req = 2'b00; alloc_ack = 1'b0; commit_valid = 2'b11;
        tick();
        commit_valid = 2'b00;
        chk("uf_flag", 32'(underflow_err), 32'd1);
        chk("uf_head", 32'(head_ptr),      32'd1);
        chk("uf_occ",  32'(occupancy),     32'd1);
        tick();
        chk("uf_sticky", 32'(underflow_err), 32'd1);
        chk("stall_cnt", stall_cycles,       EXP_STALL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
